// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: access sizes, FSM state constants and
// the default start of the instruction region.
package mem_arb_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  localparam logic [31:0] IM_BASE_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/mem_arbiter_be_gen.sv
// Byte-enable and misalignment decode for data accesses; purely combinational.
module mem_be_gen
  import mem_arb_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] be_o,
  output logic       misalign_o
);

  always_comb begin
    be_o       = 4'b0000;
    misalign_o = 1'b0;
    case (size_i)
      SIZE_BYTE: be_o = 4'b0001 << addr_i;
      SIZE_HALF: begin
        be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_i[0];
      end
      SIZE_WORD: begin
        be_o       = 4'b1111;
        misalign_o = |addr_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data.
// Optional MEM_ARB_IM_PROTECT_EN rejects data stores at or above IM_BASE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] IM_BASE     = IM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [1:0]  d_size_i,
  input  logic        d_sign_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  output logic [3:0]  mem_be_o,
  output logic        mem_sign_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
`ifdef MEM_ARB_IM_PROTECT_EN
  localparam logic PROT_EN = 1'b1;
`else
  localparam logic PROT_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic        prio_i_q, prio_i_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        own_d_q, own_d_d;
  logic        we_q, we_d;
  logic        sign_q, sign_d;
  logic        err_q, err_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  d_be;
  logic        d_misalign;
  logic        prot_err;
  logic        grant;
  logic        pick_d;
  logic [31:0] d_wdata_lane;
  logic        in_access;
  logic        in_resp;

  mem_be_gen u_be_gen (
    .size_i     (d_size_i),
    .addr_i     (d_addr_i[1:0]),
    .be_o       (d_be),
    .misalign_o (d_misalign)
  );

  assign prot_err = PROT_EN && d_we_i && (d_addr_i >= IM_BASE);
  assign grant    = (state_q == ST_IDLE) && (if_req_i || d_req_i);
  assign pick_d   = d_req_i && (!if_req_i || !prio_i_q);
  assign if_gnt_o = rst_n && grant && !pick_d;
  assign d_gnt_o  = rst_n && grant && pick_d;

  // Replicate store data across lanes so the enabled bytes carry it wherever they sit.
  always_comb begin
    case (d_size_i)
      SIZE_BYTE: d_wdata_lane = {4{d_wdata_i[7:0]}};
      SIZE_HALF: d_wdata_lane = {2{d_wdata_i[15:0]}};
      default:   d_wdata_lane = d_wdata_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    prio_i_d = prio_i_q;
    cnt_d    = cnt_q;
    own_d_d  = own_d_q;
    we_d     = we_q;
    sign_d   = sign_q;
    err_d    = err_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d  = ST_ACCESS;
          cnt_d    = WAIT_INIT;
          prio_i_d = pick_d;
          own_d_d  = pick_d;
          if (pick_d) begin
            addr_d  = d_addr_i;
            we_d    = d_we_i;
            wdata_d = d_wdata_lane;
            be_d    = d_be;
            sign_d  = d_sign_i && !d_we_i;
            err_d   = d_misalign || prot_err;
          end else begin
            addr_d  = if_addr_i;
            we_d    = 1'b0;
            wdata_d = 32'h0;
            be_d    = 4'b1111;
            sign_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          rdata_d = (err_q || we_q) ? 32'h0 : mem_rdata_i;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prio_i_q <= 1'b0;
      cnt_q    <= 4'd0;
      own_d_q  <= 1'b0;
      we_q     <= 1'b0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
      be_q     <= 4'b0000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      prio_i_q <= prio_i_d;
      cnt_q    <= cnt_d;
      own_d_q  <= own_d_d;
      we_q     <= we_d;
      sign_q   <= sign_d;
      err_q    <= err_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Rejected requests still walk through ACCESS for uniform latency, but with the port silent.
  assign in_access   = rst_n && (state_q == ST_ACCESS) && !err_q;
  assign in_resp     = rst_n && (state_q == ST_RESP);

  assign mem_addr_o  = in_access ? addr_q : 32'h0;
  assign mem_wdata_o = (in_access && we_q) ? wdata_q : 32'h0;
  assign mem_we_o    = in_access && we_q && (cnt_q == 4'd0);
  assign mem_re_o    = in_access && !we_q;
  assign mem_be_o    = in_access ? be_q : 4'b0000;
  assign mem_sign_o  = in_access && sign_q;

  assign if_rvalid_o = in_resp && !own_d_q;
  assign if_rdata_o  = if_rvalid_o ? rdata_q : 32'h0;
  assign d_rvalid_o  = in_resp && own_d_q;
  assign d_rdata_o   = d_rvalid_o ? rdata_q : 32'h0;
  assign d_err_o     = d_rvalid_o && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one WAIT_CYCLES=0 instance for the main scenarios
// and one WAIT_CYCLES=3 instance for the reset-abort case.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, if_req3 = 1'b0, d_req3 = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        d_we = 1'b0, d_sign = 1'b0;
  logic [1:0]  d_size = 2'b00;

  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_we, mem_re, mem_sign;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, d_err3, mem_we3, mem_re3, mem_sign3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
  logic [3:0]  mem_be3;

`ifdef MEM_ARB_IM_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.WAIT_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_size_i(d_size), .d_sign_i(d_sign),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_err_o(d_err),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_re_o(mem_re),
    .mem_be_o(mem_be), .mem_sign_o(mem_sign), .mem_rdata_i(mem_rdata)
  );

  mem_arbiter #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req3), .if_addr_i(if_addr), .if_gnt_o(if_gnt3), .if_rvalid_o(if_rvalid3), .if_rdata_o(if_rdata3),
    .d_req_i(d_req3), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_size_i(d_size), .d_sign_i(d_sign),
    .d_gnt_o(d_gnt3), .d_rvalid_o(d_rvalid3), .d_rdata_o(d_rdata3), .d_err_o(d_err3),
    .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_we_o(mem_we3), .mem_re_o(mem_re3),
    .mem_be_o(mem_be3), .mem_sign_o(mem_sign3), .mem_rdata_i(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    if_req = 1'b0; d_req = 1'b0; if_req3 = 1'b0; d_req3 = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; if_addr = 32'h3000; d_addr = 32'h10; d_size = 2'b10;
    repeat (2) step();
    @(negedge clk);
    checks++; if ({if_gnt, d_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", {if_gnt, d_gnt}); end
    checks++; if ({mem_we, mem_re, mem_sign, mem_be} !== 7'b0) begin errors++; $display("FAIL reset_mem_ctl: got %b expected 0", {mem_we, mem_re, mem_sign, mem_be}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata}); end
    checks++; if ({if_rvalid, d_rvalid, d_err, if_rdata, d_rdata} !== 67'h0) begin errors++; $display("FAIL reset_resp: got %h expected 0", {if_rvalid, d_rvalid, d_err, if_rdata, d_rdata}); end
    if_req = 1'b0; d_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0000_3000; mem_rdata = 32'h8C01_0004;
    @(negedge clk);
    checks++; if ({if_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL fetch_gnt: got %b expected 10", {if_gnt, d_gnt}); end
    step(); if_req = 1'b0;
    @(negedge clk);
    checks++; if ({mem_re, mem_we, mem_sign, mem_be} !== 7'b1001111) begin errors++; $display("FAIL fetch_access_ctl: got %b expected 1001111", {mem_re, mem_we, mem_sign, mem_be}); end
    checks++; if (mem_addr !== 32'h3000) begin errors++; $display("FAIL fetch_addr: got %h expected 00003000", mem_addr); end
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_early_rvalid: got %b expected 0", if_rvalid); end
    step();
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid: got %b%b expected 10", if_rvalid, d_rvalid); end
    checks++; if (if_rdata !== 32'h8C01_0004) begin errors++; $display("FAIL fetch_rdata: got %h expected 8c010004", if_rdata); end
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL fetch_resp_re: got %b expected 0", mem_re); end
    settle();
  endtask

  task automatic test_alternate();
    bit gseq[8];
    int ng = 0, nd_rv = 0, ni_rv = 0;
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1;
    if_addr = 32'h3000; d_addr = 32'h10; d_we = 1'b0; d_size = 2'b10; d_sign = 1'b0; mem_rdata = 32'h1122_3344;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (d_gnt && ng < 8) begin gseq[ng] = 1'b1; ng++; end
      if (if_gnt && ng < 8) begin gseq[ng] = 1'b0; ng++; end
      if (d_rvalid) nd_rv++;
      if (if_rvalid) ni_rv++;
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
    checks++; if (ng !== 4) begin errors++; $display("FAIL alt_grant_count: got %0d expected 4", ng); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (gseq[k] !== ((k % 2) == 0)) begin errors++; $display("FAIL alt_order[%0d]: got data=%b expected data=%b", k, gseq[k], ((k % 2) == 0)); end
    end
    checks++; if (nd_rv !== 2 || ni_rv !== 2) begin errors++; $display("FAIL alt_rvalid_count: got d=%0d i=%0d expected 2 2", nd_rv, ni_rv); end
    settle();
  endtask

  task automatic test_store_byte();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h6; d_wdata = 32'hAB; d_size = 2'b00; d_sign = 1'b0;
    @(negedge clk);
    checks++; if ({if_gnt, d_gnt} !== 2'b01) begin errors++; $display("FAIL sb_gnt: got %b expected 01", {if_gnt, d_gnt}); end
    step(); d_req = 1'b0;
    @(negedge clk);
    checks++; if ({mem_we, mem_re, mem_be} !== 6'b100100) begin errors++; $display("FAIL sb_access: got %b expected 100100", {mem_we, mem_re, mem_be}); end
    checks++; if (mem_addr !== 32'h6 || mem_wdata[23:16] !== 8'hAB) begin errors++; $display("FAIL sb_bus: got addr %h lane2 %h expected 6 ab", mem_addr, mem_wdata[23:16]); end
    step();
    @(negedge clk);
    checks++; if ({mem_we, d_rvalid, d_err} !== 3'b010) begin errors++; $display("FAIL sb_resp: got %b expected 010", {mem_we, d_rvalid, d_err}); end
    settle();
  endtask

  task automatic test_misaligned();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2; d_size = 2'b10; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL mis_gnt: got %b expected 1", d_gnt); end
    step(); d_req = 1'b0;
    @(negedge clk);
    checks++; if ({mem_re, mem_we, mem_be} !== 6'b0) begin errors++; $display("FAIL mis_strobes: got %b expected 000000", {mem_re, mem_we, mem_be}); end
    step();
    @(negedge clk);
    checks++; if ({d_rvalid, d_err} !== 2'b11 || d_rdata !== 32'h0) begin errors++; $display("FAIL mis_resp: got %b rdata %h expected 11 rdata 0", {d_rvalid, d_err}, d_rdata); end
    settle();
  endtask

  task automatic test_half_load();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h12; d_size = 2'b01; d_sign = 1'b1; mem_rdata = 32'hFFFF_8001;
    step(); d_req = 1'b0;
    @(negedge clk);
    checks++; if ({mem_re, mem_sign, mem_be} !== 6'b111100) begin errors++; $display("FAIL hl_access: got %b expected 111100", {mem_re, mem_sign, mem_be}); end
    step();
    @(negedge clk);
    checks++; if ({d_rvalid, d_err} !== 2'b10 || d_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL hl_resp: got %b rdata %h expected 10 rdata ffff8001", {d_rvalid, d_err}, d_rdata); end
    d_sign = 1'b0;
    settle();
  endtask

  task automatic test_protect();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3004; d_size = 2'b10; d_wdata = 32'hDEAD_BEEF;
    step(); d_req = 1'b0;
    @(negedge clk);
    checks++; if (mem_we !== !PROT) begin errors++; $display("FAIL prot_we: got %b expected %b", mem_we, !PROT); end
    step();
    @(negedge clk);
    checks++; if ({d_rvalid, d_err, mem_we} !== {1'b1, PROT, 1'b0}) begin errors++; $display("FAIL prot_resp: got %b expected %b", {d_rvalid, d_err, mem_we}, {1'b1, PROT, 1'b0}); end
    settle();
  endtask

  task automatic test_reset_abort();
    int nwe = 0, ndrv = 0, nirv = 0;
    d_req3 = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_size = 2'b10; d_wdata = 32'h55;
    @(negedge clk);
    checks++; if (d_gnt3 !== 1'b1) begin errors++; $display("FAIL abort_gnt: got %b expected 1", d_gnt3); end
    step(); d_req3 = 1'b0;
    @(negedge clk);
    checks++; if (mem_addr3 !== 32'h8 || mem_we3 !== 1'b0) begin errors++; $display("FAIL abort_acc1: got addr %h we %b expected 8 0", mem_addr3, mem_we3); end
    step(); rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({mem_we3, mem_addr3} !== 33'h0) begin errors++; $display("FAIL abort_in_reset: got %h expected 0", {mem_we3, mem_addr3}); end
    step(); rst_n = 1'b1; if_req3 = 1'b1; if_addr = 32'h3000;
    @(negedge clk);
    checks++; if (if_gnt3 !== 1'b1) begin errors++; $display("FAIL abort_idle_after: got gnt %b expected 1", if_gnt3); end
    step(); if_req3 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_we3) nwe++;
      if (d_rvalid3) ndrv++;
      if (if_rvalid3) nirv++;
      step();
    end
    checks++; if (nwe !== 0 || ndrv !== 0) begin errors++; $display("FAIL abort_no_we_rvalid: got we=%0d drv=%0d expected 0 0", nwe, ndrv); end
    checks++; if (nirv !== 1) begin errors++; $display("FAIL abort_followup_fetch: got %0d rvalids expected 1", nirv); end
    settle();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_alternate();
    test_store_byte();
    test_misaligned();
    test_half_load();
    test_protect();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
